mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
Multicycle control state machine for the 32-bit, 6-bit-opcode CPU. Sequences instruction fetch from the instruction memory (16-bit PC, one word per address), decode, ALU execute, data-memory access and register writeback. Drives all datapath enables and muxes. Counts retired instructions for bench checking.

Parameters:
CNT_W, 16, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
run  in  1  1 = fetch new instructions; sampled only in FETCH
opcode  in  6  IR[31:26] from external instruction register
cmp_eq  in  1  ALU compare: field1 == field2 (valid in EXEC)
cmp_lt  in  1  ALU compare: field1 < field2 signed (valid in EXEC)
pc_we  out  1  PC register load
pc_src  out  1  0 = PC+1, 1 = PC + sext(imm16), using already-incremented PC
ir_we  out  1  IR load from instruction memory
rf_we  out  1  register-file write
dmem_we  out  1  data-memory write
alu_op  out  3  0 MOV,1 NOT,2 ADD,3 SUB,4 OR,5 AND,6 XOR,7 SLT
alu_src_imm  out  1  ALU B operand = sext(imm16)
addr_sel  out  1  data address: 0 = imm16 (LWI/SWI), 1 = ALU result (LW/SW)
wb_sel  out  2  0 ALU, 1 LI imm, 2 LUI merge, 3 memory data
retire  out  1  one-cycle pulse on final cycle of each instruction
instr_count  out  CNT_W  retired-instruction count
state_o  out  3  current state for debug

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5 (HALT exists only with the optional feature).
- Reset: state FETCH, instr_count 0. While in FETCH with run=0, all strobes and muxes are 0.
- Outputs are combinational from state, opcode, cmp_eq and cmp_lt. Only state and instr_count are registered.
- FETCH, run=1: ir_we=1, pc_we=1, pc_src=0; next DECODE. With run=0, remain in FETCH. run deasserting mid-instruction has no effect until the next FETCH.
- Opcode classes and state paths:
  - NOP 000000: DECODE (retire) -> FETCH.
  - J 000001: DECODE with pc_we=1, pc_src=1 (retire) -> FETCH.
  - R-type 010xxx: DECODE -> EXEC (alu_op=opcode[2:0], alu_src_imm=0) -> WB.
  - I-ALU 110010..110111: DECODE -> EXEC (alu_op=opcode[2:0], alu_src_imm=1) -> WB.
  - Branch 1000xx: DECODE -> EXEC with alu_op=SUB. pc_we=taken, pc_src=1, retire -> FETCH.
    - Taken if: BEQ 00 eq; BNE 01 !eq; BLT 10 lt; BLE 11 lt|eq.
  - LI 111001: DECODE -> WB with wb_sel=1.
  - LUI 111010: DECODE -> WB with wb_sel=2.
  - LWI 111011: DECODE -> MEM (addr_sel=0) -> WB with wb_sel=3.
  - SWI 111100: DECODE -> MEM with addr_sel=0, dmem_we=1, retire -> FETCH.
  - LW 111101: DECODE -> EXEC (ADD, imm) -> MEM (addr_sel=1) -> WB with wb_sel=3.
  - SW 111110: DECODE -> EXEC (ADD, imm) -> MEM with addr_sel=1, dmem_we=1, retire -> FETCH.
- WB: rf_we=1, retire=1; next FETCH. In WB, alu_op, alu_src_imm and addr_sel hold the values of the preceding EXEC/MEM cycle.
- Cycle counts (FETCH through retire): NOP/J 2; LI/LUI/SWI/branch 3; ALU/LWI/SW 4; LW 5.
- Unlisted opcodes are treated as NOP: retire in DECODE.
- instr_count increments on every retire pulse and wraps to 0 after all ones.
- Asynchronous reset mid-instruction: immediate return to FETCH and count 0. No write strobe may assert during reset.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: an unlisted opcode in DECODE moves to HALT with no retire. HALT drives all strobes 0 and holds until rst; state_o=5.
- Undefined: unlisted opcodes retire as NOP; HALT is unreachable.

Test Plan:
- Reset, run=0 for 5 cycles -> state_o=0, ir_we=pc_we=0, instr_count=0. Set run=1 with opcode 010010 (ADD) -> ir_we at cycle 0, EXEC alu_op=2, rf_we in cycle 3, count=1.
- BNE (100001), cmp_eq=0 -> EXEC pc_we=1, pc_src=1, 3 cycles. Same with cmp_eq=1 -> pc_we=0. BLE with eq=1, lt=0 -> taken.
- Sequence LI, LUI, LWI, SWI, LW, SW -> paths 3, 3, 4, 3, 5, 4 cycles; wb_sel 1, 2, 3, -, 3; dmem_we only in MEM of SWI/SW; addr_sel 0, 0, 1, 1 for LWI, SWI, LW, SW.
- J (000001) -> pc_we, pc_src=1 in DECODE, 2 cycles total. NOP -> 2 cycles, no rf_we/dmem_we.
- Assert rst in EXEC of an SW -> immediate FETCH, dmem_we never asserted, instr_count=0. Drop run during LW -> LW completes, FSM then idles in FETCH.
- Opcode 101010 -> without ILLEGAL_TRAP_EN retires in 2 cycles. With it, state_o=5, count frozen, exit only by rst. Also CNT_W=4 run 16 NOPs -> count wraps to 0.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle control FSM for the 32-bit, 6-bit-opcode CPU.
// Sequences fetch, decode, ALU execute, data-memory access and register
// writeback. It drives every datapath enable and mux, and it counts
// retired instructions.
//
// Optional build macro: ILLEGAL_TRAP_EN. When it is defined, an unlisted
// opcode sends the FSM to HALT, which it leaves only on rst. When it is not
// defined, an unlisted opcode retires as a NOP.
//
// Ports:
//   clk, rst        clock (rising edge) and async active-high reset
//   run             start a new instruction; sampled only in FETCH
//   opcode          IR[31:26]
//   cmp_eq, cmp_lt  ALU compare results, valid in EXEC
//   pc_we, pc_src   PC load; pc_src: 0 = PC+1, 1 = PC + sext(imm16)
//   ir_we           IR load
//   rf_we, dmem_we  register-file and data-memory write strobes
//   alu_op          0 MOV,1 NOT,2 ADD,3 SUB,4 OR,5 AND,6 XOR,7 SLT
//   alu_src_imm     ALU B operand = sext(imm16)
//   addr_sel        data address: 0 = imm16, 1 = ALU result
//   wb_sel          0 ALU, 1 LI imm, 2 LUI merge, 3 memory data
//   retire          pulse on the last cycle of each instruction
//   instr_count     retired-instruction count (wraps)
//   state_o         current state for debug
//
// state  | meaning
// FETCH  | load IR, PC+1 (idle while run=0)
// DECODE | classify opcode; NOP/J retire here
// EXEC   | ALU operation; branches resolve and retire here
// MEM    | data-memory access; stores retire here
// WB     | register write; retire
// HALT   | illegal-opcode trap (ILLEGAL_TRAP_EN only)
module mc_ctrl_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  output logic             pc_we,
  output logic             pc_src,
  output logic             ir_we,
  output logic             rf_we,
  output logic             dmem_we,
  output logic [2:0]       alu_op,
  output logic             alu_src_imm,
  output logic             addr_sel,
  output logic [1:0]       wb_sel,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       state_o
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [CNT_W-1:0] r_count;

  logic w_is_nop, w_is_j, w_is_r, w_is_i, w_is_br;
  logic w_is_li, w_is_lui, w_is_lwi, w_is_swi, w_is_lw, w_is_sw;
  logic w_legal, w_taken;
  logic [2:0] w_exec_op;
  logic w_exec_imm;
  logic w_pc_we, w_ir_we, w_rf_we, w_dmem_we, w_retire;

  assign w_is_nop = (opcode == 6'b000000);
  assign w_is_j   = (opcode == 6'b000001);
  assign w_is_r   = (opcode[5:3] == 3'b010);
  // I-ALU covers 110010..110111; 110000 and 110001 are unlisted.
  assign w_is_i   = (opcode[5:3] == 3'b110) && (opcode[2:1] != 2'b00);
  assign w_is_br  = (opcode[5:2] == 4'b1000);
  assign w_is_li  = (opcode == 6'b111001);
  assign w_is_lui = (opcode == 6'b111010);
  assign w_is_lwi = (opcode == 6'b111011);
  assign w_is_swi = (opcode == 6'b111100);
  assign w_is_lw  = (opcode == 6'b111101);
  assign w_is_sw  = (opcode == 6'b111110);
  assign w_legal  = w_is_nop | w_is_j | w_is_r | w_is_i | w_is_br | w_is_li |
                    w_is_lui | w_is_lwi | w_is_swi | w_is_lw | w_is_sw;

  always_comb begin
    case (opcode[1:0])
      2'b00:   w_taken = cmp_eq;
      2'b01:   w_taken = ~cmp_eq;
      2'b10:   w_taken = cmp_lt;
      default: w_taken = cmp_lt | cmp_eq;
    endcase
  end

  // ALU setting used in EXEC. MEM and WB repeat it so that the ALU result
  // stays stable while it is used as an address or as writeback data.
  always_comb begin
    w_exec_op  = 3'd0;
    w_exec_imm = 1'b0;
    if (w_is_r | w_is_i) begin
      w_exec_op  = opcode[2:0];
      w_exec_imm = w_is_i;
    end else if (w_is_br) begin
      w_exec_op  = 3'd3;
    end else if (w_is_lw | w_is_sw) begin
      w_exec_op  = 3'd2;
      w_exec_imm = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_count <= '0;
    else if (w_retire) r_count <= r_count + 1'b1;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (run) w_next = S_DECODE;
      S_DECODE: begin
        if (w_is_nop | w_is_j)                           w_next = S_FETCH;
        else if (w_is_r | w_is_i | w_is_br | w_is_lw | w_is_sw) w_next = S_EXEC;
        else if (w_is_li | w_is_lui)                     w_next = S_WB;
        else if (w_is_lwi | w_is_swi)                    w_next = S_MEM;
        else
`ifdef ILLEGAL_TRAP_EN
          w_next = S_HALT;
`else
          w_next = S_FETCH;
`endif
      end
      S_EXEC: begin
        if (w_is_br)                w_next = S_FETCH;
        else if (w_is_lw | w_is_sw) w_next = S_MEM;
        else                        w_next = S_WB;
      end
      S_MEM:    w_next = (w_is_swi | w_is_sw) ? S_FETCH : S_WB;
      S_WB:     w_next = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_HALT:   w_next = S_HALT;
`endif
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_pc_we     = 1'b0;
    pc_src      = 1'b0;
    w_ir_we     = 1'b0;
    w_rf_we     = 1'b0;
    w_dmem_we   = 1'b0;
    alu_op      = 3'd0;
    alu_src_imm = 1'b0;
    addr_sel    = 1'b0;
    wb_sel      = 2'd0;
    w_retire    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_we = run;
        w_pc_we = run;
      end
      S_DECODE: begin
        w_pc_we = w_is_j;
        pc_src  = w_is_j;
`ifdef ILLEGAL_TRAP_EN
        w_retire = w_is_nop | w_is_j;
`else
        w_retire = w_is_nop | w_is_j | ~w_legal;
`endif
      end
      S_EXEC: begin
        alu_op      = w_exec_op;
        alu_src_imm = w_exec_imm;
        if (w_is_br) begin
          w_pc_we  = w_taken;
          pc_src   = 1'b1;
          w_retire = 1'b1;
        end
      end
      S_MEM: begin
        alu_op      = w_exec_op;
        alu_src_imm = w_exec_imm;
        addr_sel    = w_is_lw | w_is_sw;
        w_dmem_we   = w_is_swi | w_is_sw;
        w_retire    = w_is_swi | w_is_sw;
      end
      S_WB: begin
        alu_op      = w_exec_op;
        alu_src_imm = w_exec_imm;
        addr_sel    = w_is_lw;
        w_rf_we     = 1'b1;
        w_retire    = 1'b1;
        if (w_is_li)                 wb_sel = 2'd1;
        else if (w_is_lui)           wb_sel = 2'd2;
        else if (w_is_lwi | w_is_lw) wb_sel = 2'd3;
      end
      default: ;
    endcase
  end

  // Strobes are masked while rst is high, because FETCH is the reset state
  // and would otherwise request a fetch during reset.
  assign pc_we       = w_pc_we   & ~rst;
  assign ir_we       = w_ir_we   & ~rst;
  assign rf_we       = w_rf_we   & ~rst;
  assign dmem_we     = w_dmem_we & ~rst;
  assign retire      = w_retire  & ~rst;
  assign instr_count = r_count;
  assign state_o     = r_state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;
  logic clk = 1'b0;
  logic rst, run, cmp_eq, cmp_lt;
  logic [5:0] opcode;
  logic pc_we, pc_src, ir_we, rf_we, dmem_we, alu_src_imm, addr_sel, retire;
  logic [2:0] alu_op, state_o;
  logic [1:0] wb_sel;
  logic [15:0] instr_count;
  logic q_pc_we, q_pc_src, q_ir_we, q_rf_we, q_dmem_we, q_alu_src_imm, q_addr_sel, q_retire;
  logic [2:0] q_alu_op, q_state;
  logic [1:0] q_wb_sel;
  logic [3:0] q_count;

  mc_ctrl_fsm #(.CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
    .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .rf_we(rf_we), .dmem_we(dmem_we),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .addr_sel(addr_sel), .wb_sel(wb_sel),
    .retire(retire), .instr_count(instr_count), .state_o(state_o));

  mc_ctrl_fsm #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
    .pc_we(q_pc_we), .pc_src(q_pc_src), .ir_we(q_ir_we), .rf_we(q_rf_we), .dmem_we(q_dmem_we),
    .alu_op(q_alu_op), .alu_src_imm(q_alu_src_imm), .addr_sel(q_addr_sel), .wb_sel(q_wb_sel),
    .retire(q_retire), .instr_count(q_count), .state_o(q_state));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, m_count = 0;

  localparam int C_NOP = 0, C_J = 1, C_R = 2, C_I = 3, C_BR = 4, C_LI = 5, C_LUI = 6,
                 C_LWI = 7, C_SWI = 8, C_LW = 9, C_SW = 10, C_ILL = 11;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int cls_of(input logic [5:0] op);
    casez (op)
      6'b000000: return C_NOP;
      6'b000001: return C_J;
      6'b010???: return C_R;
      6'b1000??: return C_BR;
      6'b111001: return C_LI;
      6'b111010: return C_LUI;
      6'b111011: return C_LWI;
      6'b111100: return C_SWI;
      6'b111101: return C_LW;
      6'b111110: return C_SW;
      6'b110???: return (op[2:0] >= 3'd2) ? C_I : C_ILL;
      default:   return C_ILL;
    endcase
  endfunction

  function automatic int eff_cls(input logic [5:0] op);
    int c = cls_of(op);
`ifndef ILLEGAL_TRAP_EN
    if (c == C_ILL) c = C_NOP;
`endif
    return c;
  endfunction

  function automatic bit taken_of(input logic [5:0] op, input bit eq, input bit lt);
    case (op[1:0])
      2'd0: return eq;
      2'd1: return !eq;
      2'd2: return lt;
      default: return lt || eq;
    endcase
  endfunction

  function automatic bit writes_reg(input int c);
    return c == C_R || c == C_I || c == C_LI || c == C_LUI || c == C_LWI || c == C_LW;
  endfunction

  function automatic bit uses_alu(input int c);
    return c == C_R || c == C_I || c == C_BR || c == C_LW || c == C_SW;
  endfunction

  function automatic int path_len(input int c);
    case (c)
      C_NOP, C_J: return 2;
      C_BR, C_LI, C_LUI, C_SWI: return 3;
      C_LW: return 5;
      default: return 4;
    endcase
  endfunction

  // State visited in cycle k of an instruction of class c.
  function automatic int path_state(input int c, input int k);
    if (k == 0) return 0;
    if (k == 1) return 1;
    if (k == path_len(c) - 1 && writes_reg(c)) return 4;
    if (k == 2 && uses_alu(c)) return 2;
    return 3;
  endfunction

  // Entered just after a rising edge with the FSM in FETCH.
  task automatic exec_instr(input logic [5:0] op, input bit eq, input bit lt,
                            output int len, output int wb_r, output int addr_r,
                            output int pcwe_r, output int rf_n, output int dm_n);
    int c, n, st;
    bit last, tk;
    c = eff_cls(op); n = path_len(c); tk = taken_of(op, eq, lt);
    run = 1'b1; opcode = op; cmp_eq = eq; cmp_lt = lt;
    len = 0; rf_n = 0; dm_n = 0; wb_r = -1; addr_r = -1; pcwe_r = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      rf_n += int'(rf_we); dm_n += int'(dmem_we);
      if (k < n) begin
        st = path_state(c, k); last = (k == n - 1);
        chk($sformatf("state op=%b k=%0d", op, k), state_o, st);
        chk($sformatf("ir_we op=%b k=%0d", op, k), ir_we, k == 0);
        chk($sformatf("pc_we op=%b k=%0d", op, k), pc_we,
            k == 0 || (c == C_J && k == 1) || (c == C_BR && k == 2 && tk));
        chk($sformatf("pc_src op=%b k=%0d", op, k), pc_src,
            (c == C_J && k == 1) || (c == C_BR && k == 2));
        chk($sformatf("rf_we op=%b k=%0d", op, k), rf_we, last && writes_reg(c));
        chk($sformatf("dmem_we op=%b k=%0d", op, k), dmem_we,
            last && (c == C_SWI || c == C_SW));
        chk($sformatf("retire op=%b k=%0d", op, k), retire, last);
        if (st == 2) begin
          chk($sformatf("alu_op op=%b", op), alu_op,
              (c == C_R || c == C_I) ? int'(op[2:0]) : (c == C_BR ? 3 : 2));
          chk($sformatf("alu_src_imm op=%b", op), alu_src_imm,
              c == C_I || c == C_LW || c == C_SW);
        end
        if (st == 3)
          chk($sformatf("addr_sel op=%b", op), addr_sel, c == C_LW || c == C_SW);
        if (st == 4)
          chk($sformatf("wb_sel op=%b", op), wb_sel,
              c == C_LI ? 1 : c == C_LUI ? 2 : (c == C_LWI || c == C_LW) ? 3 : 0);
      end
      if (retire) begin
        len = k + 1; wb_r = wb_sel; addr_r = addr_sel; pcwe_r = pc_we;
        break;
      end
      @(posedge clk); #1;
      run = 1'b0;
    end
    if (len == 0) chk($sformatf("retire_timeout op=%b", op), 0, 1);
    @(posedge clk); #1;
    run = 1'b0;
    m_count++;
    chk("instr_count", instr_count, m_count & 16'hFFFF);
    chk("instr_count_w4", q_count, m_count & 15);
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; opcode = '0; cmp_eq = 1'b0; cmp_lt = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_count = 0;
  endtask

  typedef struct {
    logic [5:0] op;
    bit eq, lt;
    int len, wb, addr, pcwe, rf, dm;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int len, wb_r, addr_r, pcwe_r, rf_n, dm_n, r;
    logic [5:0] op;

    //        op         eq lt len wb addr pcwe rf dm
    tbl[0]  = '{6'b010010, 0, 0, 4,  0, -1, 0, 1, 0};  // ADD
    tbl[1]  = '{6'b100001, 0, 0, 3, -1, -1, 1, 0, 0};  // BNE taken
    tbl[2]  = '{6'b100001, 1, 0, 3, -1, -1, 0, 0, 0};  // BNE not taken
    tbl[3]  = '{6'b100011, 1, 0, 3, -1, -1, 1, 0, 0};  // BLE eq
    tbl[4]  = '{6'b100000, 0, 1, 3, -1, -1, 0, 0, 0};  // BEQ not taken
    tbl[5]  = '{6'b100010, 0, 1, 3, -1, -1, 1, 0, 0};  // BLT taken
    tbl[6]  = '{6'b111001, 0, 0, 3,  1, -1, 0, 1, 0};  // LI
    tbl[7]  = '{6'b111010, 0, 0, 3,  2, -1, 0, 1, 0};  // LUI
    tbl[8]  = '{6'b111011, 0, 0, 4,  3,  0, 0, 1, 0};  // LWI
    tbl[9]  = '{6'b111100, 0, 0, 3, -1,  0, 0, 0, 1};  // SWI
    tbl[10] = '{6'b111101, 0, 0, 5,  3,  1, 0, 1, 0};  // LW
    tbl[11] = '{6'b111110, 0, 0, 4, -1,  1, 0, 0, 1};  // SW
    tbl[12] = '{6'b000001, 0, 0, 2, -1, -1, 1, 0, 0};  // J
    tbl[13] = '{6'b000000, 0, 0, 2, -1, -1, 0, 0, 0};  // NOP
    tbl[14] = '{6'b110110, 0, 0, 4,  0, -1, 0, 1, 0};  // XORI
    tbl[15] = '{6'b010111, 1, 1, 4,  0, -1, 0, 1, 0};  // SLT

    do_reset();
    repeat (5) begin
      @(negedge clk);
      chk("idle state", state_o, 0);
      chk("idle strobes", {ir_we, pc_we, rf_we, dmem_we, retire, pc_src, alu_src_imm, addr_sel}, 0);
      chk("idle muxes", {alu_op, wb_sel}, 0);
      chk("idle count", instr_count, 0);
    end
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      exec_instr(tbl[i].op, tbl[i].eq, tbl[i].lt, len, wb_r, addr_r, pcwe_r, rf_n, dm_n);
      chk($sformatf("tbl%0d len", i), len, tbl[i].len);
      if (tbl[i].wb >= 0) chk($sformatf("tbl%0d wb_sel", i), wb_r, tbl[i].wb);
      if (tbl[i].addr >= 0) chk($sformatf("tbl%0d addr_sel", i), addr_r, tbl[i].addr);
      chk($sformatf("tbl%0d pc_we@retire", i), pcwe_r, tbl[i].pcwe);
      chk($sformatf("tbl%0d rf_we count", i), rf_n, tbl[i].rf);
      chk($sformatf("tbl%0d dmem_we count", i), dm_n, tbl[i].dm);
    end

    // run dropped during LW (exec_instr drops it after FETCH): FSM then idles.
    exec_instr(6'b111101, 0, 0, len, wb_r, addr_r, pcwe_r, rf_n, dm_n);
    chk("lw_norun len", len, 5);
    repeat (3) begin
      @(negedge clk);
      chk("post-lw idle state", state_o, 0);
      chk("post-lw idle ir_we", ir_we, 0);
      chk("post-lw count", instr_count, m_count);
    end
    @(posedge clk); #1;

    // Reset asserted in EXEC of an SW.
    run = 1'b1; opcode = 6'b111110;
    @(posedge clk); #1 run = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("sw exec state", state_o, 2);
    chk("sw exec dmem_we", dmem_we, 0);
    #1 rst = 1'b1; run = 1'b1;
    #1;
    chk("rst state", state_o, 0);
    chk("rst count", instr_count, 0);
    chk("rst dmem_we", dmem_we, 0);
    chk("rst ir_we", ir_we, 0);
    @(posedge clk); #1;
    chk("rst hold dmem_we", dmem_we, 0);
    chk("rst hold pc_we", pc_we, 0);
    rst = 1'b0; run = 1'b0; m_count = 0;

    // Unlisted opcodes.
`ifdef ILLEGAL_TRAP_EN
    run = 1'b1; opcode = 6'b101010;
    @(posedge clk); #1 run = 1'b0;
    @(negedge clk);
    chk("ill decode retire", retire, 0);
    @(posedge clk); #1 run = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("halt state", state_o, 5);
      chk("halt strobes", {ir_we, pc_we, rf_we, dmem_we, retire}, 0);
      chk("halt count", instr_count, m_count);
    end
    do_reset();
    @(negedge clk);
    chk("halt exit state", state_o, 0);
    @(posedge clk); #1;
`else
    exec_instr(6'b101010, 0, 0, len, wb_r, addr_r, pcwe_r, rf_n, dm_n);
    chk("ill 101010 len", len, 2);
    exec_instr(6'b110001, 0, 0, len, wb_r, addr_r, pcwe_r, rf_n, dm_n);
    chk("ill 110001 len", len, 2);
    chk("ill rf/dmem", rf_n + dm_n, 0);
`endif

    // 16 NOPs from reset: the 4-bit counter wraps to 0.
    do_reset();
    repeat (16) exec_instr(6'b000000, 0, 0, len, wb_r, addr_r, pcwe_r, rf_n, dm_n);
    chk("wrap count16", instr_count, 16);
    chk("wrap count4", q_count, 0);

    // Randomized instruction stream against the model.
    repeat (200) begin
      op = 6'($urandom_range(0, 63));
`ifdef ILLEGAL_TRAP_EN
      for (int t = 0; t < 64 && cls_of(op) == C_ILL; t++) op = 6'($urandom_range(0, 63));
      if (cls_of(op) == C_ILL) op = 6'b000000;
`else
      r = int'($urandom_range(0, 9));
      if (cls_of(op) == C_ILL && r < 7) op = {3'b111, 3'($urandom_range(1, 6))};
`endif
      exec_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 len, wb_r, addr_r, pcwe_r, rf_n, dm_n);
      chk($sformatf("rand len op=%b", op), len, path_len(eff_cls(op)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
